// File: rtl/saturn_bus_config.sv
// saturn_bus_config: daisy-chain CONFIGURE/UNCONFIGURE/RESET/C=ID controller and
// address decoder that picks which Saturn bus device drives the read nibble.
module saturn_bus_config #(
  parameter int NUM_DEV = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_cmd_valid,
  input  logic [2:0]           i_cmd,
  input  logic [19:0]          i_cmd_data,
  output logic                 o_cmd_ready,
  output logic                 o_cmd_done,
  input  logic [20*NUM_DEV-1:0] i_dev_id,
  output logic [19:0]          o_id,
  input  logic [19:0]          i_addr,
  output logic [NUM_DEV-1:0]   o_dev_sel,
  input  logic [4*NUM_DEV-1:0] i_dev_nibble,
  output logic [3:0]           o_nibble,
  output logic                 o_all_configured
);
  localparam int IW = $clog2(NUM_DEV);
  localparam logic [2:0] C_CFG = 3'd1, C_UNC = 3'd2, C_RST = 3'd3, C_ID = 3'd4;
  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {UNCONF, SIZED, CONFD} cfg_t;
  state_t state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic [19:0] data_q, data_d, id_q, id_d;
  logic done_q, done_d;
  cfg_t cfg_q [1:NUM_DEV-1];
  cfg_t cfg_d [1:NUM_DEV-1];
  logic [19:0] mask_q [1:NUM_DEV-1];
  logic [19:0] mask_d [1:NUM_DEV-1];
  logic [19:0] base_q [1:NUM_DEV-1];
  logic [19:0] base_d [1:NUM_DEV-1];
  logic [IW-1:0] head, unc, sel;
  logic has_head, unc_hit, all_cfg;
  // Head is the lowest unconfigured device; the highest matching index wins for decode and UNCONFIGURE.
  always_comb begin
    head = '0;
    has_head = 1'b0;
    all_cfg = 1'b1;
    unc = '0;
    unc_hit = 1'b0;
    sel = '0;
    for (int k = NUM_DEV - 1; k >= 1; k--)
      if (cfg_q[k] != CONFD) begin
        head = IW'(k);
        has_head = 1'b1;
        all_cfg = 1'b0;
      end
    for (int k = 1; k < NUM_DEV; k++) begin
      if (cfg_q[k] == CONFD && (data_q & mask_q[k]) == base_q[k]) begin
        unc = IW'(k);
        unc_hit = 1'b1;
      end
      if (cfg_q[k] == CONFD && (i_addr & mask_q[k]) == base_q[k]) sel = IW'(k);
    end
  end
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    data_d = data_q;
    id_d = id_q;
    done_d = done_q;
    cfg_d = cfg_q;
    mask_d = mask_q;
    base_d = base_q;
    if (i_clk_en) begin
      done_d = state_q == EXEC;
      if (state_q == IDLE) begin
        if (i_cmd_valid) begin
          state_d = EXEC;
          cmd_d = i_cmd;
          data_d = i_cmd_data;
        end
      end else begin
        state_d = IDLE;
        case (cmd_q)
          C_CFG:
            if (has_head) begin
              if (cfg_q[head] == UNCONF) begin
                mask_d[head] = data_q;
                cfg_d[head] = SIZED;
              end else begin
                base_d[head] = data_q & mask_q[head];
                cfg_d[head] = CONFD;
              end
            end
          C_UNC:
            if (unc_hit) begin
              cfg_d[unc] = UNCONF;
              mask_d[unc] = '0;
              base_d[unc] = '0;
            end
          C_RST:
            for (int k = 1; k < NUM_DEV; k++) begin
              cfg_d[k] = UNCONF;
              mask_d[k] = '0;
              base_d[k] = '0;
            end
          C_ID: id_d = has_head ? i_dev_id[head*20 +: 20] : '0;
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      data_q <= '0;
      id_q <= '0;
      done_q <= 1'b0;
      for (int k = 1; k < NUM_DEV; k++) begin
        cfg_q[k] <= UNCONF;
        mask_q[k] <= '0;
        base_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      data_q <= data_d;
      id_q <= id_d;
      done_q <= done_d;
      cfg_q <= cfg_d;
      mask_q <= mask_d;
      base_q <= base_d;
    end
  assign o_cmd_ready = state_q == IDLE;
  assign o_cmd_done = done_q;
  assign o_id = id_q;
  assign o_all_configured = all_cfg;
  assign o_dev_sel = {{(NUM_DEV-1){1'b0}}, 1'b1} << sel;
  assign o_nibble = i_dev_nibble[sel*4 +: 4];
endmodule

// File: tb/tb_saturn_bus_config.sv
// tb_saturn_bus_config: random and directed stimulus against a transaction-level
// model of the configuration chain and address decode.
module tb_saturn_bus_config;
  localparam int N = 4;
  logic clk = 0, rst, en = 0, valid = 0;
  logic [2:0] cmd = 0;
  logic [19:0] data = 0, addr = 0;
  logic [20*N-1:0] dev_id = 0;
  logic [4*N-1:0] dev_nib = 0;
  logic ready, done, allc;
  logic [19:0] id;
  logic [N-1:0] sel;
  logic [3:0] nib;
  int checks = 0, failures = 0;
  int m_cfg [N];
  logic [19:0] m_mask [N];
  logic [19:0] m_base [N];
  logic [19:0] m_id, m_data;
  logic [2:0] m_cmd;
  bit m_busy, m_done;
  logic [19:0] tbl [6] = '{20'hF0000, 20'hFF000, 20'hC0000, 20'hFFFFF, 20'h00000, 20'h80000};
  always #5 clk = ~clk;
  saturn_bus_config #(.NUM_DEV(N)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(en), .i_cmd_valid(valid), .i_cmd(cmd),
    .i_cmd_data(data), .o_cmd_ready(ready), .o_cmd_done(done), .i_dev_id(dev_id),
    .o_id(id), .i_addr(addr), .o_dev_sel(sel), .i_dev_nibble(dev_nib),
    .o_nibble(nib), .o_all_configured(allc));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_head();
    for (int k = 1; k < N; k++) if (m_cfg[k] != 2) return k;
    return 0;
  endfunction
  function automatic int m_owner(input logic [19:0] a);
    int o = 0;
    for (int k = 1; k < N; k++) if (m_cfg[k] == 2 && (a & m_mask[k]) == m_base[k]) o = k;
    return o;
  endfunction
  function automatic bit m_allc();
    for (int k = 1; k < N; k++) if (m_cfg[k] != 2) return 0;
    return 1;
  endfunction
  task automatic m_clear(input int k);
    m_cfg[k] = 0;
    m_mask[k] = 0;
    m_base[k] = 0;
  endtask
  task automatic m_apply();
    int h = m_head();
    int u;
    case (m_cmd)
      3'd1:
        if (h != 0) begin
          if (m_cfg[h] == 0) begin
            m_mask[h] = m_data;
            m_cfg[h] = 1;
          end else begin
            m_base[h] = m_data & m_mask[h];
            m_cfg[h] = 2;
          end
        end
      3'd2: begin
        u = m_owner(m_data);
        if (u != 0) m_clear(u);
      end
      3'd3: for (int k = 1; k < N; k++) m_clear(k);
      3'd4: m_id = (h != 0) ? dev_id[h*20 +: 20] : 20'h0;
      default: ;
    endcase
  endtask
  // Transaction-level model: a command taken on one enabled edge completes on the next.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_done = 0;
      m_id = 0;
      for (int k = 0; k < N; k++) m_clear(k);
    end else if (en) begin
      if (m_busy) begin
        m_apply();
        m_busy = 0;
        m_done = 1;
      end else begin
        m_done = 0;
        if (valid) begin
          m_busy = 1;
          m_cmd = cmd;
          m_data = data;
        end
      end
    end
  end
  always @(negedge clk)
    if (rst === 1'b0) begin
      int o;
      o = m_owner(addr);
      chk("sel", sel, 1 << o);
      chk("nibble", nib, dev_nib[o*4 +: 4]);
      chk("all_configured", allc, m_allc());
      chk("ready", ready, !m_busy);
      chk("done", done, m_done);
      chk("id", id, m_id);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] c, input logic [19:0] d);
    int t = 0;
    while (!ready && t < 20) begin
      step();
      t++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
    valid = 1;
    cmd = c;
    data = d;
    step();
    valid = 0;
    step();
  endtask
  initial begin
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    en = 1;
    addr = 20'h12345;
    dev_nib = 16'hDCBA;
    #1;
    chk("rst_sel", sel, 4'b0001);
    chk("rst_nibble", nib, 4'hA);
    chk("rst_allc", allc, 0);
    chk("rst_ready", ready, 1);
    chk("rst_id", id, 0);
    issue(3'd1, 20'hF0000);
    chk("done_pulse1", done, 1);
    issue(3'd1, 20'h80000);
    chk("done_pulse2", done, 1);
    step();
    chk("done_single", done, 0);
    addr = 20'h8ABCD;
    #1;
    chk("dev1_sel", sel, 4'b0010);
    chk("dev1_nibble", nib, 4'hB);
    addr = 20'h7FFFF;
    #1;
    chk("dev1_miss", sel, 4'b0001);
    dev_id[2*20 +: 20] = 20'h0000A;
    issue(3'd4, 20'h0);
    chk("cid_dev2", id, 20'h0000A);
    issue(3'd1, 20'hFF000);
    issue(3'd1, 20'h80000);
    issue(3'd1, 20'hC0000);
    issue(3'd1, 20'hC0000);
    addr = 20'h80100;
    #1;
    chk("ovl_dev2", sel, 4'b0100);
    addr = 20'h81000;
    #1;
    chk("ovl_dev1", sel, 4'b0010);
    addr = 20'hC1234;
    #1;
    chk("ovl_dev3", sel, 4'b1000);
    chk("allc_full", allc, 1);
    issue(3'd1, 20'h12345);
    chk("nohead_done", done, 1);
    chk("nohead_sel", sel, 4'b1000);
    issue(3'd4, 20'h0);
    chk("cid_nohead", id, 20'h0);
    issue(3'd2, 20'h80100);
    addr = 20'h80100;
    #1;
    chk("unc_sel", sel, 4'b0010);
    chk("unc_allc", allc, 0);
    issue(3'd3, 20'h0);
    #1;
    chk("reset_cmd_sel", sel, 4'b0001);
    issue(3'd1, 20'hF0000);
    valid = 1;
    cmd = 3'd1;
    data = 20'h80000;
    step();
    valid = 0;
    #1 rst = 1;
    #1 rst = 0;
    step();
    chk("abort_no_done", done, 0);
    chk("abort_ready", ready, 1);
    issue(3'd1, 20'hFFFFF);
    issue(3'd1, 20'h12345);
    addr = 20'h12345;
    #1;
    chk("abort_dev1_unconf", sel, 4'b0010);
    valid = 1;
    cmd = 3'd1;
    data = 20'hFF000;
    step();
    valid = 0;
    en = 0;
    repeat (3) begin
      step();
      chk("en_low_exec", done, 0);
    end
    en = 1;
    step();
    chk("en_return_done", done, 1);
    en = 0;
    repeat (3) begin
      step();
      chk("done_held", done, 1);
    end
    en = 1;
    step();
    chk("done_release", done, 0);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      en = $urandom_range(0, 4) != 0;
      valid = $urandom_range(0, 1);
      cmd = r < 5 ? 3'd1 : r == 5 ? 3'd2 : r == 6 ? 3'd3 : r == 7 ? 3'd4 : r == 8 ? 3'd0 : 3'($urandom_range(5, 7));
      data = $urandom_range(0, 1) ? tbl[$urandom_range(0, 5)] : 20'($urandom);
      addr = $urandom_range(0, 2) == 0 ? data : 20'($urandom);
      dev_nib = 16'($urandom);
      dev_id = {$urandom, $urandom, 16'($urandom)};
      if ($urandom_range(0, 80) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
